serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl_if.sv | 23 ++
 rtl/serial_adder_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between an add requester and the serial adder.
// The master drives start and the operands; the slave returns status and result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
        output start, a, b,
        input  busy, done, sum, carry
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, carry
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-add cell, made from two half adders and an OR,
// adds two WIDTH-bit operands LSB-first at one bit per clock. The result is
// only published once the whole word is finished.

// Single-bit half adder used twice to form the full-add cell.
module halfAdder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_adder_ctrl_if.slave bus
);
    // The counter only has to reach WIDTH-1, and it is at least one bit wide.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cf;
    logic [CW-1:0]    cnt;

    logic ha1_sum;
    logic ha1_carry;
    logic ha2_sum;
    logic ha2_carry;
    logic cout;
    logic last_step;
    logic [WIDTH-1:0] sr_next;

    // Full-add cell: operand bits first, then the running carry.
    halfAdder u_ha1 (.a(sa[0]),   .b(sb[0]), .sum(ha1_sum), .carry(ha1_carry));
    halfAdder u_ha2 (.a(ha1_sum), .b(cf),    .sum(ha2_sum), .carry(ha2_carry));

    assign cout      = ha1_carry | ha2_carry;
    assign sr_next   = {ha2_sum, sr[WIDTH-1:1]};
    assign last_step = (cnt == CW'(WIDTH - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start is only looked at while idle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs decode straight from the state register, so nothing on the
    // request side reaches them combinationally.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load on accept, shift one bit per RUN cycle, publish on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa      <= '0;
            sb      <= '0;
            sr      <= '0;
            cf      <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        sr  <= '0;
                        cf  <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sr <= sr_next;
                    sa <= {1'b0, sa[WIDTH-1:1]};
                    sb <= {1'b0, sb[WIDTH-1:1]};
                    cf <= cout;
                    if (last_step) begin
                        sum_q   <= sr_next;
                        carry_q <= cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed add vectors plus a word-level model
// (plain integer addition with a fixed latency) compared every cycle.
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_compared = 0;
    int n_failed   = 0;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Model state: phase 0 idle, 1 running, 2 reporting; result from a+b directly.
    int               m_phase = 0;
    int               m_left  = 0;
    logic [WIDTH:0]   m_pend  = '0;
    logic [WIDTH-1:0] m_sum   = '0;
    logic             m_carry = 1'b0;

    // Word-level model: accepted request completes WIDTH cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_left  = 0;
            m_sum   = '0;
            m_carry = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (bus.start) begin
                        m_pend  = {1'b0, bus.a} + {1'b0, bus.b};
                        m_left  = WIDTH;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_sum   = m_pend[WIDTH-1:0];
                        m_carry = m_pend[WIDTH];
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            n_compared++;
            if ({bus.busy, bus.done, bus.carry, bus.sum} !==
                {(m_phase == 1), (m_phase == 2), m_carry, m_sum}) begin
                n_failed++;
                $display("[TB] FAIL model_cycle t=%0t got busy=%b done=%b carry=%b sum=%h want busy=%b done=%b carry=%b sum=%h",
                         $time, bus.busy, bus.done, bus.carry, bus.sum,
                         (m_phase == 1), (m_phase == 2), m_carry, m_sum);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s got %h want %h", name, actual, expected);
        end
    endtask

    // Issue one add from a negedge, wait for done, check latency, busy length and result.
    // When hold_chk is set, sum/carry must keep hold_sum/hold_carry throughout RUN.
    task automatic applyStimulus(input string name,
                                 input logic [7:0] a_in, input logic [7:0] b_in,
                                 input logic [7:0] exp_sum, input logic exp_carry,
                                 input bit hold_chk,
                                 input logic [7:0] hold_sum, input logic hold_carry);
        int lat;
        int busy_cycles;
        bit seen;
        lat = 0;
        busy_cycles = 0;
        seen = 1'b0;
        bus.start = 1'b1;
        bus.a     = a_in;
        bus.b     = b_in;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            lat++;
            if (bus.busy) busy_cycles++;
            if (hold_chk) begin
                checkOutput({name, "_hold_sum"}, 32'(bus.sum), 32'(hold_sum));
                checkOutput({name, "_hold_carry"}, 32'(bus.carry), 32'(hold_carry));
            end
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({name, "_latency"}, 32'(lat), 32'(WIDTH));
        checkOutput({name, "_busy_len"}, 32'(busy_cycles), 32'(WIDTH));
        checkOutput({name, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        checkOutput({name, "_carry"}, 32'(bus.carry), 32'(exp_carry));
    endtask

    initial begin
        int dones;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy",  32'(bus.busy),  32'd0);
        checkOutput("reset_done",  32'(bus.done),  32'd0);
        checkOutput("reset_sum",   32'(bus.sum),   32'd0);
        checkOutput("reset_carry", 32'(bus.carry), 32'd0);

        // Basic adds with hand-computed results.
        applyStimulus("add_5a_35", 8'h5A, 8'h35, 8'h8F, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        applyStimulus("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        applyStimulus("add_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset between edges clears outputs at once.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_busy",  32'(bus.busy),  32'd0);
        checkOutput("async_rst_done",  32'(bus.done),  32'd0);
        checkOutput("async_rst_sum",   32'(bus.sum),   32'd0);
        checkOutput("async_rst_carry", 32'(bus.carry), 32'd0);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("post_rst_idle_sum",  32'(bus.sum),  32'd0);
        checkOutput("post_rst_idle_busy", 32'(bus.busy), 32'd0);

        applyStimulus("add_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        // Start during RUN is ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h20;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checkOutput("ignored_start_dones", 32'(dones), 32'd1);
        checkOutput("ignored_start_sum",   32'(bus.sum),   32'h30);
        checkOutput("ignored_start_carry", 32'(bus.carry), 32'd0);
        checkOutput("ignored_start_idle",  32'(bus.busy),  32'd0);

        // Back-to-back with start held and operands changing every cycle.
        dones = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.a = 8'(i * 37 + 3);
            bus.b = 8'(i * 91 + 5);
            @(negedge clk);
            if (bus.done) dones++;
        end
        bus.start = 1'b0;
        checkOutput("b2b_dones", 32'(dones), 32'd3);
        // Third accept sees i=20: a=8'(743)=8'hE7, b=8'(1825)=8'h21 -> 0x108.
        checkOutput("b2b_last_sum",   32'(bus.sum),   32'h08);
        checkOutput("b2b_last_carry", 32'(bus.carry), 32'd1);
        repeat (2) @(negedge clk);

        // Reset in the middle of an operation: no done pulse.
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrun_rst_busy", 32'(bus.busy), 32'd0);
        #1 rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checkOutput("midrun_rst_dones", 32'(dones), 32'd0);
        checkOutput("midrun_rst_sum",   32'(bus.sum),   32'd0);
        checkOutput("midrun_rst_carry", 32'(bus.carry), 32'd0);
        applyStimulus("add_01_01", 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0);

        // Result holds through the next RUN and changes only when it completes.
        @(negedge clk);
        applyStimulus("add_80_80", 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        applyStimulus("hold_01_02", 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 8'h00, 1'b1);

        repeat (3) @(negedge clk);
        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule
